// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode, the writeback paths and the ID/EX operand stage.
// The pipeline control side is the master; the operand stage is the slave.
interface id_ex_operand_stage_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic [RW-1:0] id_rd;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [DW-1:0] id_rs1_data;
    logic [DW-1:0] id_rs2_data;
    logic [DW-1:0] id_imm;
    logic          id_use_imm;
    logic [3:0]    id_aluc;
    logic [1:0]    id_alub;
    logic          id_unsig;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;

    logic [DW-1:0] ex_result;
    logic [RW-1:0] mem_rd;
    logic          mem_reg_write;
    logic [DW-1:0] mem_result;
    logic [RW-1:0] wb_rd;
    logic          wb_reg_write;
    logic [DW-1:0] wb_result;

    logic          hold;
    logic          flush;

    logic          hazard_stall;
    logic          ex_valid;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [DW-1:0] ex_store_data;
    logic [3:0]    ex_aluc;
    logic [1:0]    ex_alub;
    logic          ex_unsig;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_use_imm, id_aluc,
               id_alub, id_unsig, id_reg_write, id_mem_read, id_mem_write,
               ex_result, mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_result, hold, flush,
        input  hazard_stall, ex_valid, ex_a, ex_b, ex_store_data, ex_aluc,
               ex_alub, ex_unsig, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_use_imm, id_aluc,
               id_alub, id_unsig, id_reg_write, id_mem_read, id_mem_write,
               ex_result, mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_result, hold, flush,
        output hazard_stall, ex_valid, ex_a, ex_b, ex_store_data, ex_aluc,
               ex_alub, ex_unsig, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the 16-bit ALU: operand forwarding
// (EX > MEM > WB > register file), load-use bubble, hold and flush.
module id_ex_operand_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input logic                  clk,
    input logic                  rst,
    id_ex_operand_stage_if.slave bus
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] store_data;
        logic [3:0]    aluc;
        logic [1:0]    alub;
        logic          unsig;
        logic [RW-1:0] rd;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } stage_t;

    stage_t        stage_q;
    stage_t        stage_d;
    stage_t        captured;
    logic          ex_fwd_ok;
    logic          load_use;
    logic [DW-1:0] fwd_rs1;
    logic [DW-1:0] fwd_rs2;

    // A load in EX has no data yet, so it never forwards; the bubble covers it.
    function automatic logic [DW-1:0] resolve(
        input logic [RW-1:0] src,
        input logic [DW-1:0] rf_data,
        input logic          ex_ok,
        input logic [RW-1:0] ex_rd,
        input logic [DW-1:0] ex_res,
        input logic          mem_we,
        input logic [RW-1:0] mem_rd,
        input logic [DW-1:0] mem_res,
        input logic          wb_we,
        input logic [RW-1:0] wb_rd,
        input logic [DW-1:0] wb_res
    );
        logic [DW-1:0] value;
        if (src == '0) begin
            value = '0;
        end else if (ex_ok && ex_rd == src) begin
            value = ex_res;
        end else if (mem_we && mem_rd == src) begin
            value = mem_res;
        end else if (wb_we && wb_rd == src) begin
            value = wb_res;
        end else begin
            value = rf_data;
        end
        return value;
    endfunction

    assign ex_fwd_ok = stage_q.valid & stage_q.reg_write & ~stage_q.mem_read;

    always_comb begin
        fwd_rs1 = resolve(bus.id_rs1, bus.id_rs1_data, ex_fwd_ok, stage_q.rd,
                          bus.ex_result, bus.mem_reg_write, bus.mem_rd,
                          bus.mem_result, bus.wb_reg_write, bus.wb_rd,
                          bus.wb_result);
        fwd_rs2 = resolve(bus.id_rs2, bus.id_rs2_data, ex_fwd_ok, stage_q.rd,
                          bus.ex_result, bus.mem_reg_write, bus.mem_rd,
                          bus.mem_result, bus.wb_reg_write, bus.wb_rd,
                          bus.wb_result);
    end

    always_comb begin
        load_use = bus.id_valid & stage_q.valid & stage_q.mem_read &
                   (stage_q.rd != '0) &
                   ((bus.id_use_rs1 & (stage_q.rd == bus.id_rs1)) |
                    (bus.id_use_rs2 & (stage_q.rd == bus.id_rs2)));
    end

    // Flush or hold already freezes decode, so the stall request is masked.
    assign bus.hazard_stall = load_use & ~bus.hold & ~bus.flush;

    always_comb begin
        captured            = '0;
        captured.valid      = 1'b1;
        captured.a          = fwd_rs1;
        captured.b          = bus.id_use_imm ? bus.id_imm : fwd_rs2;
        captured.store_data = fwd_rs2;
        captured.aluc       = bus.id_aluc;
        captured.alub       = bus.id_alub;
        captured.unsig      = bus.id_unsig;
        captured.rd         = bus.id_rd;
        captured.reg_write  = bus.id_reg_write;
        captured.mem_read   = bus.id_mem_read;
        captured.mem_write  = bus.id_mem_write;
    end

    // Bubbles are all-zero: ALUC=0 drives the ALU to 0 and ALUB=0 never branches.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = '0;
        end else if (bus.hold) begin
            stage_d = stage_q;
        end else if (load_use || !bus.id_valid) begin
            stage_d = '0;
        end else begin
            stage_d = captured;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.ex_valid      = stage_q.valid;
    assign bus.ex_a          = stage_q.a;
    assign bus.ex_b          = stage_q.b;
    assign bus.ex_store_data = stage_q.store_data;
    assign bus.ex_aluc       = stage_q.aluc;
    assign bus.ex_alub       = stage_q.alub;
    assign bus.ex_unsig      = stage_q.unsig;
    assign bus.ex_rd         = stage_q.rd;
    assign bus.ex_reg_write  = stage_q.reg_write;
    assign bus.ex_mem_read   = stage_q.mem_read;
    assign bus.ex_mem_write  = stage_q.mem_write;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the 16-bit ALU.
- Latches decoded control (ALUC, ALUB, Unsig, writeback/memory flags) and resolves the two ALU operands through a forwarding network (EX > MEM > WB > register file).
- Detects load-use hazards and inserts bubbles; honours a downstream hold and a branch flush.
- All outputs are registered and drive the ALU `a`, `b`, `ALUC`, `ALUB` and `Unsig` inputs directly.

Parameters:
- DW, 16, datapath width.
- RW, 4, register index width (16 architectural registers; R0 reads as zero).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1, id_rs2, id_rd  in  RW each  source and destination register indices.
- id_use_rs1, id_use_rs2  in  1 each  the instruction reads that source.
- id_rs1_data, id_rs2_data  in  DW each  register-file read data.
- id_imm  in  DW  sign-/zero-extended immediate.
- id_use_imm  in  1  operand b takes id_imm instead of rs2.
- id_aluc  in  4  ALU opcode.
- id_alub  in  2  branch condition.
- id_unsig  in  1  unsigned compare.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control flags.
- ex_result  in  DW  ALU out of the instruction now held in this stage.
- mem_rd  in  RW;  mem_reg_write  in  1;  mem_result  in  DW  EX/MEM stage writeback info.
- wb_rd  in  RW;  wb_reg_write  in  1;  wb_result  in  DW  MEM/WB stage writeback info.
- hold  in  1  downstream stall; freeze this stage.
- flush  in  1  squash this stage (taken branch/jump).
- hazard_stall  out  1  combinational; decode and fetch must hold.
- ex_valid  out  1;  ex_a, ex_b, ex_store_data  out  DW;  ex_aluc  out  4;  ex_alub  out  2;  ex_unsig  out  1;  ex_rd  out  RW;  ex_reg_write, ex_mem_read, ex_mem_write  out  1.

Behaviour:
- Reset (async, immediate): every registered output is 0. ALUC=0 makes the ALU output 0; ex_valid=0.
- Forwarding (combinational, per source s in {rs1, rs2}):
  - Match EX when ex_valid & ex_reg_write & !ex_mem_read & ex_rd==s & s!=0.
  - Otherwise match MEM when mem_reg_write & mem_rd==s & s!=0.
  - Otherwise match WB when wb_reg_write & wb_rd==s & s!=0.
  - Otherwise use register-file data. s==0 always yields 0.
- Operand b: fwd_rs2 when id_use_imm=0, else id_imm. ex_store_data always takes fwd_rs2.
- hazard_stall = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)). It is forced to 0 while hold or flush is asserted.
- Per-edge priority: flush > hold > hazard > load.
  - flush: bubble (ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_aluc, ex_alub = 0). ALUB=0 means never-taken. Operand regs are don't-care; they are cleared to 0.
  - hold: all registers keep their value.
  - hazard: bubble as above. Next cycle the load is in MEM and the MEM forward path supplies the data.
  - load: capture the id_* fields and forwarded operands. ex_valid <= id_valid. When id_valid=0, load as bubble.
- Latency: one cycle from decode to ALU inputs. Forwarding adds no cycles except the single load-use bubble.
- Simultaneous flush and hazard: flush wins; hazard_stall=0.
- Reset mid-hold: registers clear and hold is ignored until reset deasserts.
- Width: DW bits pass through unchanged; no truncation or extension inside this block.

Test Plan:
- Reset asserted mid-operation with ex_a=0x1234 -> all outputs 0 asynchronously, before the next clk edge.
- Back-to-back ADD R1 (ex_result=0x0005), then SUB reading R1 with id_rs1_data=0x0000 -> ex_a=0x0005 next cycle (EX forward).
- Three sources match R2: EX with ex_mem_read=0 and ex_result=0x00AA, MEM=0x00BB, WB=0x00CC, id_use_imm=0 -> ex_b=0x00AA. With ex_mem_read=1 -> hazard_stall=1, a bubble is inserted, and next cycle MEM=0x00BB is used.
- Forwarding to R0 with id_rs1_data=0x0000 and mem_rd=0, mem_result=0xFFFF -> ex_a=0x0000. id_use_imm=1 with id_imm=0xFFF0 -> ex_b=0xFFF0 while ex_store_data=fwd_rs2.
- hold=1 for 3 cycles with changing id_* -> outputs frozen. flush=1 coincident with hazard -> ex_valid=0, ex_aluc=0, hazard_stall=0.
